// File: rtl/decap_packet_stream_if.sv
// Aurora RX frame stream and DFX word valid/ready handshake for decap_packet_stream.
interface decap_packet_stream_if #(
    parameter int AURORA_DATA_WIDTH = 64,
    parameter int HDR_WIDTH         = 9,
    parameter int DFX_W             = 1034
);
    logic [AURORA_DATA_WIDTH-1:0] rx_data;
    logic                         rx_valid;
    logic [HDR_WIDTH-1:0]         header_pkt_recv;
    logic [DFX_W-1:0]             data_dfx_recv;
    logic                         valid_dfx_data;
    logic                         dfx_ready;

    modport master (
        output rx_data, rx_valid, dfx_ready,
        input  header_pkt_recv, data_dfx_recv, valid_dfx_data
    );

    modport slave (
        input  rx_data, rx_valid, dfx_ready,
        output header_pkt_recv, data_dfx_recv, valid_dfx_data
    );
endinterface

// File: rtl/decap_packet_stream.sv
// Aurora RX decapsulator: reassembles one DFX word from NUM_FRAMES headered frames.
// Optional macro DECAP_ERR_CNT_EN adds a saturating error counter (err_cnt_clr/err_cnt).
module decap_packet_stream #(
    parameter int DATA_WIDTH        = 1024,
    parameter int ADDR_WIDTH        = 10,
    parameter int AURORA_DATA_WIDTH = 64,
    parameter int HDR_WIDTH         = 9,
    parameter int TIMEOUT_CYCLES    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    decap_packet_stream_if.slave  bus,
    output logic                  decap_done,
    output logic                  err_seq,
    output logic                  err_len,
    output logic                  err_sync,
    output logic                  err_timeout,
    output logic                  err_overflow
`ifdef DECAP_ERR_CNT_EN
    ,
    input  logic                  err_cnt_clr,
    output logic [15:0]           err_cnt
`endif
);
    localparam int DFX_W      = DATA_WIDTH + ADDR_WIDTH;
    localparam int PLD_W      = AURORA_DATA_WIDTH - HDR_WIDTH;
    localparam int NUM_FRAMES = (DFX_W + PLD_W - 1) / PLD_W;
    localparam int LAST_W     = DFX_W - (NUM_FRAMES - 1) * PLD_W;
    localparam int IDX_W      = HDR_WIDTH - 2;
    localparam int TMO_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FRAMES - 1);

    typedef enum logic {IDLE, ASSEMBLE} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     cnt_q, cnt_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic [DFX_W-1:0]     asm_q, asm_d;
    logic [HDR_WIDTH-1:0] hdr_q, hdr_d;
    logic [DFX_W-1:0]     hold_data_q;
    logic [HDR_WIDTH-1:0] hold_hdr_q;
    logic                 hold_valid_q;

    logic                 wr_en, complete, load;
    logic [IDX_W-1:0]     wr_slot;
    logic                 seq_d, len_d, sync_d, tmo_err_d;

    logic [HDR_WIDTH-1:0] hdr_in;
    logic [PLD_W-1:0]     pld;
    logic                 sof, eof;
    logic [IDX_W-1:0]     idx;

    assign hdr_in = bus.rx_data[HDR_WIDTH-1:0];
    assign pld    = bus.rx_data[AURORA_DATA_WIDTH-1:HDR_WIDTH];
    assign sof    = hdr_in[8];
    assign eof    = hdr_in[7];
    assign idx    = hdr_in[IDX_W-1:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        hdr_d     = hdr_q;
        wr_en     = 1'b0;
        wr_slot   = '0;
        complete  = 1'b0;
        seq_d     = 1'b0;
        len_d     = 1'b0;
        sync_d    = 1'b0;
        tmo_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                tmo_d = '0;
                cnt_d = '0;
                if (bus.rx_valid) begin
                    if (sof && idx == '0) begin
                        hdr_d = hdr_in;
                        if (NUM_FRAMES == 1) begin
                            if (eof) begin
                                wr_en    = 1'b1;
                                complete = 1'b1;
                            end else begin
                                len_d = 1'b1;
                            end
                        end else begin
                            wr_en   = 1'b1;
                            cnt_d   = IDX_W'(1);
                            state_d = ASSEMBLE;
                        end
                    end else begin
                        sync_d = 1'b1;
                    end
                end
            end
            ASSEMBLE: begin
                if (bus.rx_valid) begin
                    tmo_d = '0;
                    if (sof && idx == '0) begin
                        // A fresh SOF aborts the current packet but is kept as the new start.
                        seq_d = 1'b1;
                        hdr_d = hdr_in;
                        wr_en = 1'b1;
                        cnt_d = IDX_W'(1);
                    end else if (sof || idx != cnt_q) begin
                        seq_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else if (eof != (cnt_q == LAST_IDX)) begin
                        len_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        wr_en   = 1'b1;
                        wr_slot = cnt_q;
                        if (cnt_q == LAST_IDX) begin
                            complete = 1'b1;
                            cnt_d    = '0;
                            state_d  = IDLE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    tmo_err_d = 1'b1;
                    tmo_d     = '0;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
        endcase
    end

    // asm_d already holds the current frame's slice, so the holding register loads it directly.
    always_comb begin
        asm_d = asm_q;
        for (int unsigned k = 0; k < NUM_FRAMES - 1; k++) begin
            if (wr_en && wr_slot == IDX_W'(k))
                asm_d[k*PLD_W +: PLD_W] = pld;
        end
        if (wr_en && wr_slot == LAST_IDX)
            asm_d[(NUM_FRAMES-1)*PLD_W +: LAST_W] = pld[LAST_W-1:0];
    end

    assign load = complete && (!hold_valid_q || bus.dfx_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            tmo_q        <= '0;
            asm_q        <= '0;
            hdr_q        <= '0;
            hold_data_q  <= '0;
            hold_hdr_q   <= '0;
            hold_valid_q <= 1'b0;
            decap_done   <= 1'b0;
            err_seq      <= 1'b0;
            err_len      <= 1'b0;
            err_sync     <= 1'b0;
            err_timeout  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tmo_q        <= tmo_d;
            asm_q        <= asm_d;
            hdr_q        <= hdr_d;
            if (load) begin
                hold_data_q <= asm_d;
                hold_hdr_q  <= hdr_d;
            end
            hold_valid_q <= load || (hold_valid_q && !bus.dfx_ready);
            decap_done   <= load;
            err_seq      <= seq_d;
            err_len      <= len_d;
            err_sync     <= sync_d;
            err_timeout  <= tmo_err_d;
            err_overflow <= complete && !load;
        end
    end

    assign bus.data_dfx_recv   = hold_data_q;
    assign bus.header_pkt_recv = hold_hdr_q;
    assign bus.valid_dfx_data  = hold_valid_q;

`ifdef DECAP_ERR_CNT_EN
    logic any_err;
    assign any_err = seq_d || len_d || sync_d || tmo_err_d || (complete && !load);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt <= '0;
        else if (err_cnt_clr)
            err_cnt <= '0;
        else if (any_err && err_cnt != '1)
            err_cnt <= err_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_decap_packet_stream.sv
// Directed self-checking bench for decap_packet_stream at default parameters.
module tb_decap_packet_stream;
    localparam int AW    = 64;
    localparam int HW    = 9;
    localparam int DFX_W = 1034;
    localparam int PLD_W = 55;
    localparam int NF    = 19;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decap_packet_stream_if #(.AURORA_DATA_WIDTH(AW), .HDR_WIDTH(HW), .DFX_W(DFX_W)) bus ();

    logic decap_done, err_seq, err_len, err_sync, err_timeout, err_overflow;
`ifdef DECAP_ERR_CNT_EN
    logic        err_cnt_clr;
    logic [15:0] err_cnt;
`endif

    decap_packet_stream #(
        .DATA_WIDTH(1024), .ADDR_WIDTH(10), .AURORA_DATA_WIDTH(AW),
        .HDR_WIDTH(HW), .TIMEOUT_CYCLES(255)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .decap_done(decap_done),
        .err_seq(err_seq),
        .err_len(err_len),
        .err_sync(err_sync),
        .err_timeout(err_timeout),
        .err_overflow(err_overflow)
`ifdef DECAP_ERR_CNT_EN
        ,
        .err_cnt_clr(err_cnt_clr),
        .err_cnt(err_cnt)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [DFX_W-1:0] obs, input logic [DFX_W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Error vector order: {seq, len, sync, timeout, overflow}
    function automatic logic [4:0] errs();
        return {err_seq, err_len, err_sync, err_timeout, err_overflow};
    endfunction

    function automatic logic [PLD_W-1:0] pl(input int seed, input int k);
        return {16'(seed), 32'hC0DE_0000 | 32'(k), 7'(k)};
    endfunction

    function automatic logic [DFX_W-1:0] exp_word(input int seed);
        logic [DFX_W-1:0] w;
        logic [PLD_W-1:0] p;
        w = '0;
        for (int k = 0; k < NF - 1; k++) w[k*PLD_W +: PLD_W] = pl(seed, k);
        p = pl(seed, NF - 1);
        w[990 +: 44] = p[43:0];
        return w;
    endfunction

    task automatic send(input bit sof, input bit eof, input int idx, input logic [PLD_W-1:0] p);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = {p, sof, eof, 7'(idx)};
    endtask

    task automatic idle();
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
    endtask

    task automatic send_frames(input int seed, input int first, input int last);
        for (int k = first; k <= last; k++) send(k == 0, k == NF - 1, k, pl(seed, k));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DFX_W-1:0] w;
        logic [PLD_W-1:0] p;
        bus.rx_valid  = 1'b0;
        bus.rx_data   = '0;
        bus.dfx_ready = 1'b0;
`ifdef DECAP_ERR_CNT_EN
        err_cnt_clr = 1'b0;
`endif
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid", bus.valid_dfx_data, 0);
        check("rst_data", bus.data_dfx_recv, 0);
        check("rst_hdr", bus.header_pkt_recv, 0);
        check("rst_done", decap_done, 0);
        check("rst_errs", errs(), 0);
        rst_n = 1'b1;
        idle();

        // Clean packet, latency 1 cycle after frame 18
        send_frames(1, 0, NF - 1);
        idle();
        check("p1_valid", bus.valid_dfx_data, 1);
        check("p1_done", decap_done, 1);
        check("p1_errs", errs(), 0);
        check("p1_hdr", bus.header_pkt_recv, 9'h100);
        check("p1_data", bus.data_dfx_recv, exp_word(1));
        w = bus.data_dfx_recv;
        p = pl(1, 18);
        check("p1_slice0", w[0 +: 55], pl(1, 0));
        check("p1_slice17", w[935 +: 55], pl(1, 17));
        check("p1_top", w[1033:990], p[43:0]);
        idle();
        check("p1_done_pulse", decap_done, 0);
        check("p1_hold", bus.valid_dfx_data, 1);
        bus.dfx_ready = 1'b1;
        idle();
        check("p1_drain", bus.valid_dfx_data, 0);

        // Sequence error: index 5 where 4 expected
        send_frames(2, 0, 3);
        send(0, 0, 5, pl(2, 5));
        idle();
        check("seq_err", errs(), 5'b10000);
        idle();
        check("seq_pulse", errs(), 0);
        send_frames(3, 0, NF - 1);
        idle();
        check("p3_done", decap_done, 1);
        check("p3_data", bus.data_dfx_recv, exp_word(3));

        // Length errors: early EOF, missing EOF
        send_frames(4, 0, 9);
        send(0, 1, 10, pl(4, 10));
        idle();
        check("len_early", errs(), 5'b01000);
        check("len_early_done", decap_done, 0);
        send_frames(4, 0, NF - 2);
        send(0, 0, NF - 1, pl(4, NF - 1));
        idle();
        check("len_late", errs(), 5'b01000);
        check("len_late_done", decap_done, 0);

        // Timeout after 255 idle cycles, then stray frames raise sync errors
        send_frames(5, 0, 7);
        repeat (254) idle();
        idle();
        check("tmo_254", errs(), 0);
        idle();
        check("tmo_255", errs(), 5'b00010);
        send(0, 0, 8, pl(5, 8));
        send(0, 0, 9, pl(5, 9));
        check("sync_f8", errs(), 5'b00100);
        idle();
        check("sync_f9", errs(), 5'b00100);
        idle();
        check("sync_clear", errs(), 0);

        // Overflow with holding register full
        bus.dfx_ready = 1'b0;
        send_frames(6, 0, NF - 1);
        idle();
        check("p6_done", decap_done, 1);
        send_frames(7, 0, NF - 1);
        idle();
        check("ovf_err", errs(), 5'b00001);
        check("ovf_done", decap_done, 0);
        check("ovf_keep", bus.data_dfx_recv, exp_word(6));
        send_frames(8, 0, NF - 2);
        send(0, 1, NF - 1, pl(8, NF - 1));
        bus.dfx_ready = 1'b1;
        idle();
        bus.dfx_ready = 1'b0;
        check("reload_errs", errs(), 0);
        check("reload_done", decap_done, 1);
        check("reload_valid", bus.valid_dfx_data, 1);
        check("reload_data", bus.data_dfx_recv, exp_word(8));
        bus.dfx_ready = 1'b1;
        idle();
        check("reload_drain", bus.valid_dfx_data, 0);

        // Reset mid-packet with a full holding register
        bus.dfx_ready = 1'b0;
        send_frames(10, 0, NF - 1);
        idle();
        check("p10_valid", bus.valid_dfx_data, 1);
        send_frames(9, 0, 8);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", bus.valid_dfx_data, 0);
        check("mid_rst_data", bus.data_dfx_recv, 0);
        check("mid_rst_hdr", bus.header_pkt_recv, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        check("post_rst_errs", errs(), 0);
        check("post_rst_done", decap_done, 0);
        bus.dfx_ready = 1'b1;
        send_frames(11, 0, NF - 1);
        idle();
        check("p11_done", decap_done, 1);
        check("p11_data", bus.data_dfx_recv, exp_word(11));

`ifdef DECAP_ERR_CNT_EN
        // Error counter: three sync errors, clear, clear priority
        check("cnt_start", err_cnt, 0);
        send(0, 0, 3, pl(12, 3));
        send(0, 0, 4, pl(12, 4));
        send(0, 0, 5, pl(12, 5));
        idle();
        check("cnt_three", err_cnt, 3);
        err_cnt_clr = 1'b1;
        idle();
        check("cnt_clr", err_cnt, 0);
        send(0, 0, 6, pl(12, 6));
        idle();
        check("cnt_clr_prio", err_cnt, 0);
        err_cnt_clr = 1'b0;
        idle();
        check("cnt_after", err_cnt, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/decap_packet_stream.md
Name: decap_packet_stream

Overview:
- Parametrised Aurora RX decapsulator. Reassembles one DFX word (DATA_WIDTH data + ADDR_WIDTH address) from NUM_FRAMES consecutive Aurora frames.
- Each frame carries a HDR_WIDTH-bit header in its low bits and payload in its upper bits.
- Adds header-based framing checks, timeout, and a valid/ready output with a one-deep holding register.
- Sits between the Aurora RX user interface and the DFX reconfiguration/write path of an output port.

Parameters:
- DATA_WIDTH, 1024, DFX payload data bits.
- ADDR_WIDTH, 10, DFX address bits.
- AURORA_DATA_WIDTH, 64, Aurora user data width.
- HDR_WIDTH, 9, per-frame header bits; fixed layout below, must be 9.
- TIMEOUT_CYCLES, 255, maximum idle cycles between frames inside a packet.
- Derived (localparam, not overridable):
  - DFX_W = DATA_WIDTH + ADDR_WIDTH
  - PLD_W = AURORA_DATA_WIDTH - HDR_WIDTH
  - NUM_FRAMES = ceil(DFX_W / PLD_W)
  - LAST_W = DFX_W - (NUM_FRAMES-1)*PLD_W
  - Defaults give DFX_W=1034, PLD_W=55, NUM_FRAMES=19, LAST_W=44.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  AURORA_DATA_WIDTH  Aurora frame; [8:0] header, [63:9] payload
- rx_valid  in  1  frame valid; no backpressure, frame consumed every valid cycle
- header_pkt_recv  out  HDR_WIDTH  header of the SOF frame of the delivered packet
- data_dfx_recv  out  DFX_W  reassembled word; frame k payload occupies bits [k*PLD_W +: PLD_W]
- valid_dfx_data  out  1  output holding register full
- dfx_ready  in  1  consumer accept; transfer when valid_dfx_data && dfx_ready
- decap_done  out  1  one-cycle pulse when a complete packet is loaded into the holding register
- err_seq  out  1  pulse: frame index mismatch
- err_len  out  1  pulse: EOF missing or early
- err_sync  out  1  pulse: non-SOF frame received in IDLE
- err_timeout  out  1  pulse: inter-frame gap exceeded
- err_overflow  out  1  pulse: completed packet dropped because the holding register was still full

Behaviour:
- Reset: all outputs 0, state IDLE, frame_cnt 0, assembly register 0, timeout counter 0.
- Header layout: bit 8 SOF, bit 7 EOF, bits 6:0 frame index.
- IDLE:
  - rx_valid with SOF=1 and index=0: store payload in slice 0, latch header, frame_cnt=1, go ASSEMBLE.
  - If NUM_FRAMES==1, EOF must also be 1; the packet completes the same cycle.
  - rx_valid with any other header: discard frame, pulse err_sync.
- ASSEMBLE, on rx_valid:
  - Index != frame_cnt, or SOF=1: pulse err_seq, go IDLE. A frame with SOF=1 and index=0 is instead treated as a new packet start: it restarts assembly and still pulses err_seq.
  - EOF=1 with frame_cnt < NUM_FRAMES-1, or EOF=0 with frame_cnt == NUM_FRAMES-1: pulse err_len, go IDLE.
  - Otherwise store the slice and increment frame_cnt.
  - Last frame: only payload bits [9 +: LAST_W] are used; bits above are ignored.
- Completion: on the last valid frame, go IDLE and load the holding register.
  - Holding register is loaded if it is empty, or if it is being emptied in the same cycle (valid_dfx_data && dfx_ready).
  - The loaded word is the previously assembled slices combined with the current frame's slice; none of the final frame is lost.
  - On load: valid_dfx_data=1 and decap_done=1 on the next edge. Latency is 1 cycle from the last rx_valid to valid_dfx_data.
  - Otherwise: drop the packet, pulse err_overflow; holding register unchanged.
- Holding register: data_dfx_recv and header_pkt_recv are stable while valid_dfx_data=1. valid_dfx_data clears on the cycle after acceptance unless reloaded in that cycle.
- Timeout: counter increments on each ASSEMBLE cycle without rx_valid and clears on rx_valid. Reaching TIMEOUT_CYCLES pulses err_timeout and goes IDLE; the partial packet is discarded.
- All error pulses last exactly 1 cycle and are mutually exclusive per cycle.
- Reset mid-packet discards all state; no done or error pulse is generated.

Optional Feature:
- Macro: DECAP_ERR_CNT_EN.
- Defined:
  - Adds ports err_cnt_clr (in, 1) and err_cnt (out, 16).
  - err_cnt increments on any error pulse and saturates at 16'hFFFF.
  - err_cnt_clr forces 0 and takes priority over an increment in the same cycle.
  - Reset value 0.
- Undefined: no ports, no counter logic.

Test Plan:
- 19 back-to-back frames, index 0..18, SOF on 0, EOF on 18, payload pattern k -> valid_dfx_data=1 one cycle after frame 18, decap_done pulse, each slice matches, bits [1033:990] = frame 18 rx_data[52:9].
- Frame with index 5 arrives where 4 is expected -> err_seq pulse, IDLE; next clean 19-frame packet delivered correctly.
- EOF on index 10 -> err_len pulse; frame 18 without EOF -> err_len pulse; no decap_done in either case.
- Stall 255 cycles after frame 7 -> err_timeout pulse; subsequent frames 8.. -> err_sync pulses until the next SOF.
- dfx_ready=0 while two packets complete -> second packet raises err_overflow, first data retained. Repeat with dfx_ready=1 on the completion cycle -> second packet loaded, no err_overflow.
- rst_n asserted at frame 9 -> all outputs 0; a fresh packet after reset is delivered. With DECAP_ERR_CNT_EN, 3 errors give err_cnt=3, err_cnt_clr gives 0.
